// File: rtl/appr_mult_pkg.sv
// appr_mult_pkg: shared widths and accumulator state encoding for the approximate-multiplier datapath
package appr_mult_pkg;
  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_CNT_W  = 16;
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } acc_state_t;
endpackage

// File: rtl/appr_prod_acc_if.sv
// appr_prod_acc_if: product-beat input stream and result output stream of the accumulator
interface appr_prod_acc_if #(
  parameter int PROD_W = appr_mult_pkg::DEF_PROD_W,
  parameter int ACC_W  = appr_mult_pkg::DEF_ACC_W,
  parameter int CNT_W  = appr_mult_pkg::DEF_CNT_W
);
  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/appr_prod_acc_sat_add.sv
// sat_add: signed add of a narrow addend to a wide accumulator, clamped to the accumulator range
module sat_add
  import appr_mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_add,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);
  logic [ACC_W:0] w_full;
  // one guard bit: overflow shows as guard bit differing from the result sign, guard bit gives the true sign
  always_comb begin
    w_full = {i_acc[ACC_W-1], i_acc} + {{(ACC_W+1-PROD_W){i_add[PROD_W-1]}}, i_add};
    o_ovf  = w_full[ACC_W] ^ w_full[ACC_W-1];
    o_sum  = !o_ovf ? w_full[ACC_W-1:0] :
             w_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
endmodule

// File: rtl/appr_prod_acc.sv
// appr_prod_acc: saturating dot-product accumulator with beat count and sticky saturation flag
module appr_prod_acc
  import appr_mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  appr_prod_acc_if.slave     bus
);
  acc_state_t       r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt, w_sum;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_sat, w_sat_nxt, w_ovf, w_accept;

  sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_sat_add (
    .i_acc (r_acc),
    .i_add (bus.in_prod),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // outputs come straight from registers so in_prod never reaches an output combinationally
  always_comb begin
    bus.in_ready  = (r_state == ST_ACC) && !clr;
    bus.out_valid = r_state == ST_DONE;
    bus.out_sum   = r_acc;
    bus.out_count = r_cnt;
    bus.out_sat   = r_sat;
    w_accept      = bus.in_valid && bus.in_ready;
  end

  // flush (clr, or result taken) wins over everything; otherwise fold in an accepted beat
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_sat_nxt   = r_sat;
    if (clr || (r_state == ST_DONE && bus.out_ready)) begin
      w_state_nxt = ST_ACC;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_sat_nxt   = 1'b0;
    end else if (w_accept) begin
      w_state_nxt = bus.in_last ? ST_DONE : ST_ACC;
      w_acc_nxt   = w_sum;
      w_cnt_nxt   = &r_cnt ? r_cnt : r_cnt + 1'b1;
      w_sat_nxt   = r_sat | w_ovf;
    end
  end

  // state register with asynchronous reset discarding any partial or held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
    end
  end
endmodule

// File: tb/tb_appr_prod_acc.sv
// tb_appr_prod_acc: directed self-checking bench for the saturating product accumulator
module tb_appr_prod_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int checks = 0;
  int failures = 0;

  appr_prod_acc_if #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) bus ();

  appr_prod_acc dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic signed [31:0] p, input logic last);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_sum !== 40'd0) begin failures++; $display("FAIL reset_sum got=%0d exp=0", $signed(bus.out_sum)); end
    checks++; if (bus.out_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.out_count); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", bus.out_sat); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    beat(32'sd100, 1'b0);
    checks++; if (bus.out_sum !== 40'd100 || bus.out_count !== 16'd1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_running got sum=%0d cnt=%0d v=%b exp sum=100 cnt=1 v=0", $signed(bus.out_sum), bus.out_count, bus.out_valid); end
    beat(-32'sd30, 1'b0);
    beat(32'sd7, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_sum !== 40'd77) begin failures++; $display("FAIL basic_sum got=%0d exp=77", $signed(bus.out_sum)); end
    checks++; if (bus.out_count !== 16'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", bus.out_count); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", bus.out_sat); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready got=%b exp=0", bus.in_ready); end
    take_result();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 40'd0 || bus.out_count !== 16'd0) begin failures++; $display("FAIL basic_release got v=%b sum=%0d cnt=%0d exp 0 0 0", bus.out_valid, $signed(bus.out_sum), bus.out_count); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) beat(32'sd2147483647, i == 300);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL sat_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_sum !== 40'd549755813887) begin failures++; $display("FAIL sat_sum got=%0d exp=549755813887", $signed(bus.out_sum)); end
    checks++; if (bus.out_count !== 16'd300) begin failures++; $display("FAIL sat_count got=%0d exp=300", bus.out_count); end
    checks++; if (bus.out_sat !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", bus.out_sat); end
    take_result();
    checks++; if (bus.out_sat !== 1'b0 || bus.out_sum !== 40'd0) begin failures++; $display("FAIL sat_release got sat=%b sum=%0d exp 0 0", bus.out_sat, $signed(bus.out_sum)); end
  endtask

  task automatic test_hold();
    beat(32'sd11, 1'b0);
    beat(32'sd22, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_prod  = 32'sd50;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd33 || bus.out_count !== 16'd2 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_cycle%0d got v=%b sum=%0d cnt=%0d rdy=%b exp v=1 sum=33 cnt=2 rdy=0", i, bus.out_valid, $signed(bus.out_sum), bus.out_count, bus.in_ready); end
    end
    take_result();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_count !== 16'd0 || bus.out_sum !== 40'd0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got v=%b cnt=%0d sum=%0d rdy=%b exp v=0 cnt=0 sum=0 rdy=1", bus.out_valid, bus.out_count, $signed(bus.out_sum), bus.in_ready); end
  endtask

  task automatic test_single();
    logic [39:0] exp_sum;
    exp_sum = -40'sd1073741824;
    beat(-32'sd1073741824, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum || bus.out_count !== 16'd1) begin failures++; $display("FAIL single got v=%b sum=%0d cnt=%0d exp v=1 sum=-1073741824 cnt=1", bus.out_valid, $signed(bus.out_sum), bus.out_count); end
    take_result();
  endtask

  task automatic test_clr();
    beat(32'sd5, 1'b0);
    beat(32'sd6, 1'b0);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 32'sd100;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_sum !== 40'd0 || bus.out_count !== 16'd0) begin failures++; $display("FAIL clr_flush got sum=%0d cnt=%0d exp 0 0", $signed(bus.out_sum), bus.out_count); end
    beat(32'sd2, 1'b0);
    beat(32'sd3, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd5 || bus.out_count !== 16'd2) begin failures++; $display("FAIL clr_after got v=%b sum=%0d cnt=%0d exp v=1 sum=5 cnt=2", bus.out_valid, $signed(bus.out_sum), bus.out_count); end
    clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 40'd0) begin failures++; $display("FAIL clr_done got v=%b sum=%0d exp v=0 sum=0", bus.out_valid, $signed(bus.out_sum)); end
  endtask

  task automatic test_rst_mid();
    beat(32'sd10, 1'b0);
    beat(32'sd20, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_sum !== 40'd0 || bus.out_count !== 16'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got sum=%0d cnt=%0d v=%b exp 0 0 0", $signed(bus.out_sum), bus.out_count, bus.out_valid); end
    #2;
    rst = 1'b0;
    beat(32'sd9, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 40'd9 || bus.out_count !== 16'd1) begin failures++; $display("FAIL rst_fresh got v=%b sum=%0d cnt=%0d exp v=1 sum=9 cnt=1", bus.out_valid, $signed(bus.out_sum), bus.out_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 40'd0 || bus.out_count !== 16'd0) begin failures++; $display("FAIL rst_done got v=%b sum=%0d cnt=%0d exp 0 0 0", bus.out_valid, $signed(bus.out_sum), bus.out_count); end
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_stale got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_single();
    test_clr();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/appr_prod_acc.md
APPR_PROD_ACC -- requirements
Module: appr_prod_acc

Interface
REQ-001 SHALL have parameter PROD_W, default 32, width of signed product consumed from the approximate multiplier output.
REQ-002 SHALL have parameter ACC_W, default 40, width of the signed accumulator and result.
REQ-003 SHALL have parameter CNT_W, default 16, width of the beat counter.
REQ-004 SHALL provide port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port clr  input  1  synchronous flush of the current accumulation.
REQ-007 SHALL provide port in_valid  input  1  product beat present.
REQ-008 SHALL provide port in_prod  input  PROD_W  two's-complement product.
REQ-009 SHALL provide port in_last  input  1  final beat of the dot product.
REQ-010 SHALL provide port in_ready  output  1  block accepts a beat this cycle.
REQ-011 SHALL provide port out_valid  output  1  result held.
REQ-012 SHALL provide port out_ready  input  1  consumer takes the result.
REQ-013 SHALL provide port out_sum  output  ACC_W  signed accumulated result.
REQ-014 SHALL provide port out_count  output  CNT_W  number of beats accepted.
REQ-015 SHALL provide port out_sat  output  1  saturation occurred during this accumulation.

Function
REQ-016 SHALL implement two states: ACC (accepting beats) and DONE (result held).
REQ-017 in_ready SHALL be 1 only in ACC with clr=0; it SHALL be 0 in DONE.
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-019 On acceptance, the accumulator SHALL become sat(acc + sign-extended in_prod), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-020 On any clamp, the sticky saturation flag SHALL set and stay set until the result is taken, clr, or rst.
REQ-021 On acceptance, the count SHALL increment, holding at 2^CNT_W-1 with no wrap.
REQ-022 An accepted beat with in_last=1 SHALL move the state to DONE; out_valid SHALL be 1 in the next cycle (latency 1 from last beat).
REQ-023 In DONE, out_sum, out_count and out_sat SHALL remain stable until out_ready=1 at a rising edge.
REQ-024 On out_valid and out_ready, the state SHALL return to ACC with accumulator, count and flag zeroed; no beat SHALL be accepted in that same cycle.
REQ-025 In ACC, out_valid SHALL be 0; out_sum, out_count and out_sat SHALL show the running values.
REQ-026 clr=1 SHALL force ACC and zero all state in either state; a simultaneous in_valid beat SHALL be dropped.
REQ-027 clr SHALL take priority over out_ready and in_last.
REQ-028 A single beat with in_last=1 SHALL produce a valid result with count 1.

Reset
REQ-029 rst=1 SHALL immediately force state ACC, accumulator 0, count 0, out_sat 0, out_valid 0; in_ready SHALL be 1 after release.
REQ-030 Reset mid-accumulation or in DONE SHALL discard all partial results; no output SHALL be produced for them.

Structure
REQ-031 PROD_W, ACC_W, CNT_W defaults and the ACC/DONE state encoding SHALL live in shared package appr_mult_pkg, reused by multiplier-side blocks.
REQ-032 Saturating add SHALL be a sub-module sat_add (inputs: ACC_W accumulator, PROD_W addend; outputs: clamped sum, overflow flag).
REQ-033 The datapath SHALL have no combinational path from in_prod to any output.

Verification
REQ-034 The bench SHALL cover: beats 100, -30, 7 (last) -> out_valid next cycle, out_sum=77, out_count=3, out_sat=0.
REQ-035 The bench SHALL cover: 300 beats of 2147483647, last on 300th -> out_sum=549755813887, out_count=300, out_sat=1.
REQ-036 The bench SHALL cover: result held with out_ready=0 for 5 cycles -> out_valid=1, values stable, in_ready=0 throughout; release -> ACC, zeros.
REQ-037 The bench SHALL cover: single beat -1073741824 with in_last -> out_sum=-1073741824, out_count=1.
REQ-038 The bench SHALL cover: clr asserted with in_valid after beats 5, 6 -> beat dropped; next beats 2, 3 (last) -> out_sum=5, out_count=2.
REQ-039 The bench SHALL cover: rst pulsed between clock edges after 2 beats and in DONE -> outputs zero immediately, out_valid=0, no stale result.
